// File: rtl/smc777_pkg.sv
// rtl/smc777_pkg.sv - shared types and constants for the smc777 ioctl upload path
package smc777_pkg;

    localparam int         IOCTL_ADDR_W     = 25;
    localparam logic [7:0] UPLOAD_INDEX_DEF = 8'h02;
    localparam logic [7:0] DIN_UNSERVED     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEMAND,
        ST_PREFETCH,
        ST_FLUSH
    } upload_state_t;

endpackage

// File: rtl/smc777_upload_ctrl_if.sv
// rtl/smc777_upload_ctrl_if.sv - ioctl upload bus and core memory read port
interface smc777_upload_ctrl_if #(
    parameter int MEM_AW = 16
);
    import smc777_pkg::*;

    logic                    ioctl_upload;
    logic [7:0]              ioctl_index;
    logic                    ioctl_rd;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic [7:0]              ioctl_din;
    logic                    ioctl_wait;
    logic                    mem_req;
    logic [MEM_AW-1:0]       mem_addr;
    logic                    mem_ack;
    logic [7:0]              mem_rdata;
    logic                    cpu_hold;

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_ack, mem_rdata,
        output ioctl_din, ioctl_wait, mem_req, mem_addr, cpu_hold
    );

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_ack, mem_rdata,
        input  ioctl_din, ioctl_wait, mem_req, mem_addr, cpu_hold
    );

endinterface

// File: rtl/smc777_upload_ctrl.sv
// rtl/smc777_upload_ctrl.sv - ioctl upload responder with one-byte sequential prefetch
module smc777_upload_ctrl
    import smc777_pkg::*;
#(
    parameter logic [7:0] UPLOAD_INDEX = UPLOAD_INDEX_DEF,
    parameter int         MEM_AW       = 16,
    parameter int         MEM_SIZE     = 65536
) (
    input  logic                clk,
    input  logic                reset,
    smc777_upload_ctrl_if.slave bus
);

    localparam logic [IOCTL_ADDR_W:0] MEM_LIMIT = (IOCTL_ADDR_W + 1)'(MEM_SIZE);

    upload_state_t     state, state_n;
    logic [7:0]        din_q, din_n;
    logic              wait_q, wait_n;
    logic              req_q, req_n;
    logic [MEM_AW-1:0] addr_q, addr_n;
    logic              hold_q, hold_n;
    logic              pf_valid, pf_valid_n;
    logic [MEM_AW-1:0] pf_addr, pf_addr_n;
    logic [7:0]        pf_data, pf_data_n;
    logic [MEM_AW-1:0] pend_addr, pend_n;

    logic              active, served;
    logic [MEM_AW-1:0] host_addr;
    logic              do_launch;
    logic [MEM_AW-1:0] launch_base;

    // Prefetch only when addr+1 neither wraps the memory address nor leaves the backed range.
    function automatic logic pf_ok(input logic [MEM_AW-1:0] a);
        logic [MEM_AW:0] nxt;
        nxt = {1'b0, a} + (MEM_AW + 1)'(1);
        return !nxt[MEM_AW] && ({{(IOCTL_ADDR_W - MEM_AW){1'b0}}, nxt} < MEM_LIMIT);
    endfunction

    assign active    = bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
    assign served    = bus.ioctl_rd && active && ({1'b0, bus.ioctl_addr} < MEM_LIMIT);
    assign host_addr = bus.ioctl_addr[MEM_AW-1:0];

    always_comb begin
        state_n     = state;
        din_n       = din_q;
        wait_n      = wait_q;
        req_n       = req_q;
        addr_n      = addr_q;
        pf_valid_n  = pf_valid && active;
        pf_addr_n   = pf_addr;
        pf_data_n   = pf_data;
        pend_n      = pend_addr;
        do_launch   = 1'b0;
        launch_base = addr_q;

        if (bus.ioctl_rd && !served) begin
            din_n = DIN_UNSERVED;
        end

        if (!bus.ioctl_upload) begin
            // Session closed: release the host, drain any outstanding request.
            wait_n = 1'b0;
            if (state != ST_IDLE && bus.mem_ack) begin
                state_n = ST_IDLE;
                req_n   = 1'b0;
            end
        end else begin
            case (state)
                ST_DEMAND: begin
                    if (bus.mem_ack) begin
                        din_n     = bus.mem_rdata;
                        wait_n    = 1'b0;
                        do_launch = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (bus.mem_ack) begin
                        addr_n  = pend_addr;
                        state_n = ST_DEMAND;
                    end
                end
                ST_PREFETCH: begin
                    if (bus.mem_ack) begin
                        pf_data_n  = bus.mem_rdata;
                        pf_valid_n = active;
                        req_n      = 1'b0;
                        state_n    = ST_IDLE;
                    end else if (served) begin
                        wait_n  = 1'b1;
                        pend_n  = host_addr;
                        state_n = (host_addr == pf_addr) ? ST_DEMAND : ST_FLUSH;
                    end
                end
                default: ;
            endcase

            // A prefetch completing in the same cycle as a rd lets the rd see the fresh buffer.
            if (served && (state == ST_IDLE || (state == ST_PREFETCH && bus.mem_ack))) begin
                if (pf_valid_n && host_addr == pf_addr) begin
                    din_n       = pf_data_n;
                    do_launch   = 1'b1;
                    launch_base = host_addr;
                end else begin
                    wait_n  = 1'b1;
                    req_n   = 1'b1;
                    addr_n  = host_addr;
                    state_n = ST_DEMAND;
                end
            end

            if (do_launch) begin
                if (active && pf_ok(launch_base)) begin
                    req_n      = 1'b1;
                    addr_n     = launch_base + MEM_AW'(1);
                    pf_addr_n  = launch_base + MEM_AW'(1);
                    pf_valid_n = 1'b0;
                    state_n    = ST_PREFETCH;
                end else begin
                    req_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
        end

        hold_n = bus.ioctl_upload || (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            din_q     <= 8'h00;
            wait_q    <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            hold_q    <= 1'b0;
            pf_valid  <= 1'b0;
            pf_addr   <= '0;
            pf_data   <= 8'h00;
            pend_addr <= '0;
        end else begin
            state     <= state_n;
            din_q     <= din_n;
            wait_q    <= wait_n;
            req_q     <= req_n;
            addr_q    <= addr_n;
            hold_q    <= hold_n;
            pf_valid  <= pf_valid_n;
            pf_addr   <= pf_addr_n;
            pf_data   <= pf_data_n;
            pend_addr <= pend_n;
        end
    end

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.cpu_hold   = hold_q;

endmodule
